// File: rtl/stream_serializer.sv
// Transmit-side width converter: one IN_WIDTH word in, IN_WIDTH/OUT_WIDTH beats out, LSB-first.
// s_ready depends combinationally on m_ready so a new word can load on the last beat.
module stream_serializer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic [15:0]          words_sent
);

  localparam int NUM_BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || NUM_BEATS < 1) begin : g_width_check
    $error("stream_serializer: IN_WIDTH must be a positive multiple of OUT_WIDTH");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                r_state;
  logic [IN_WIDTH-1:0]   r_shreg;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic [15:0]           r_words;

  logic                  w_beat_hs;
  logic                  w_last_hs;

  assign w_beat_hs = r_m_valid & m_ready;
  assign w_last_hs = w_beat_hs & r_m_last;

  assign s_ready    = (r_state == IDLE) | ((r_state == SEND) & r_m_last & m_ready);
  assign m_valid    = r_m_valid;
  assign m_data     = r_shreg[OUT_WIDTH-1:0];
  assign m_last     = r_m_last;
  assign words_sent = r_words;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_beat_cnt <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_words    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (s_valid) begin
            r_shreg    <= s_data;
            r_beat_cnt <= '0;
            r_m_valid  <= 1'b1;
            r_m_last   <= (LAST_BEAT == '0);
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (w_last_hs) begin
            r_words <= r_words + 16'd1;
            // Reload straight from the last beat keeps back-to-back words bubble-free.
            if (s_valid) begin
              r_shreg    <= s_data;
              r_beat_cnt <= '0;
              r_m_last   <= (LAST_BEAT == '0);
            end else begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_state   <= IDLE;
            end
          end else if (w_beat_hs) begin
            r_shreg    <= r_shreg >> OUT_WIDTH;
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            r_m_last   <= ((r_beat_cnt + CNT_W'(1)) == LAST_BEAT);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench: a 32->8 serializer for beat sequencing and a 8->8 build for the
// single-beat slice and the 16-bit words_sent wrap with a beat scoreboard.
module tb_stream_serializer;

  logic        clk = 1'b0;
  logic        reset;

  logic        s_valid, s_ready, m_valid, m_ready, m_last;
  logic [31:0] s_data;
  logic [7:0]  m_data;
  logic [15:0] words_sent;

  logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_last;
  logic [7:0]  b_s_data, b_m_data;
  logic [15:0] b_words_sent;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb_q[$];
  int         sb_in, sb_out, sb_bad, cyc;
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  stream_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8)) u_dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .words_sent(words_sent)
  );

  stream_serializer #(.IN_WIDTH(8), .OUT_WIDTH(8)) u_dut_b (
    .clk(clk), .reset(reset),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
    .words_sent(b_words_sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] d, input logic lst);
    chk({tag, " valid"}, {31'd0, m_valid}, 32'd1);
    chk({tag, " data"},  {24'd0, m_data}, {24'd0, d});
    chk({tag, " last"},  {31'd0, m_last}, {31'd0, lst});
  endtask

  initial begin
    reset = 1'b1;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst m_data", {24'd0, m_data}, 32'd0);
    chk("rst m_last", {31'd0, m_last}, 32'd0);
    chk("rst words", {16'd0, words_sent}, 32'd0);
    chk("rst b_m_valid", {31'd0, b_m_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle s_ready", {31'd0, s_ready}, 32'd1);

    // Single word, beat one cycle after accept
    s_valid = 1'b1; s_data = 32'hDDCCBBAA;
    @(negedge clk);
    s_valid = 1'b0; s_data = 32'h0BADF00D;
    chk_beat("t1 b0", 8'hAA, 1'b0);
    @(negedge clk); chk_beat("t1 b1", 8'hBB, 1'b0);
    @(negedge clk); chk_beat("t1 b2", 8'hCC, 1'b0);
    @(negedge clk); chk_beat("t1 b3", 8'hDD, 1'b1);
    chk("t1 s_ready last", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    chk("t1 idle valid", {31'd0, m_valid}, 32'd0);
    chk("t1 words", {16'd0, words_sent}, 32'd1);

    // Back-to-back words with s_valid held
    s_valid = 1'b1; s_data = 32'h03020100;
    @(negedge clk);
    s_data = 32'h07060504;
    for (int i = 0; i < 8; i++) begin
      chk_beat("t2 beat", 8'(i), (i % 4) == 3);
      chk("t2 s_ready", {31'd0, s_ready}, ((i % 4) == 3) ? 32'd1 : 32'd0);
      if (i == 4) s_valid = 1'b0;
      @(negedge clk);
    end
    chk("t2 idle valid", {31'd0, m_valid}, 32'd0);
    chk("t2 words", {16'd0, words_sent}, 32'd3);

    // Backpressure during beat BB
    s_valid = 1'b1; s_data = 32'hDDCCBBAA;
    @(negedge clk);
    s_valid = 1'b0;
    chk_beat("t3 b0", 8'hAA, 1'b0);
    @(negedge clk);
    chk_beat("t3 b1", 8'hBB, 1'b0);
    m_ready = 1'b0;
    chk("t3 stall s_ready", {31'd0, s_ready}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk_beat("t3 hold", 8'hBB, 1'b0);
    end
    m_ready = 1'b1;
    @(negedge clk); chk_beat("t3 b2", 8'hCC, 1'b0);
    @(negedge clk); chk_beat("t3 b3", 8'hDD, 1'b1);
    @(negedge clk);
    chk("t3 idle valid", {31'd0, m_valid}, 32'd0);
    chk("t3 words", {16'd0, words_sent}, 32'd4);

    // Reset mid-word
    s_valid = 1'b1; s_data = 32'hDDCCBBAA;
    @(negedge clk);
    s_valid = 1'b0;
    chk_beat("t4 b0", 8'hAA, 1'b0);
    @(negedge clk);
    chk_beat("t4 b1", 8'hBB, 1'b0);
    reset = 1'b1;
    #1;
    chk("t4 async valid", {31'd0, m_valid}, 32'd0);
    chk("t4 async words", {16'd0, words_sent}, 32'd0);
    chk("t4 async data", {24'd0, m_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t4 no replay", {31'd0, m_valid}, 32'd0);
    s_valid = 1'b1; s_data = 32'h44332211;
    @(negedge clk);
    s_valid = 1'b0;
    chk_beat("t4 n0", 8'h11, 1'b0);
    @(negedge clk); chk_beat("t4 n1", 8'h22, 1'b0);
    @(negedge clk); chk_beat("t4 n2", 8'h33, 1'b0);
    @(negedge clk); chk_beat("t4 n3", 8'h44, 1'b1);
    @(negedge clk);
    chk("t4 idle valid", {31'd0, m_valid}, 32'd0);
    chk("t4 words", {16'd0, words_sent}, 32'd1);

    // Single-beat build acts as a registered slice
    b_s_valid = 1'b1; b_s_data = 8'hab;
    chk("t6 s_ready", {31'd0, b_s_ready}, 32'd1);
    @(negedge clk);
    b_s_valid = 1'b0;
    chk("t6 valid", {31'd0, b_m_valid}, 32'd1);
    chk("t6 data", {24'd0, b_m_data}, 32'h000000ab);
    chk("t6 last", {31'd0, b_m_last}, 32'd1);
    @(negedge clk);
    chk("t6 idle valid", {31'd0, b_m_valid}, 32'd0);
    chk("t6 words", {16'd0, b_words_sent}, 32'd1);

    // Remaining 65535 words through the single-beat build to wrap words_sent
    sb_in = 0; sb_out = 0; sb_bad = 0; cyc = 0;
    b_s_data = 8'($urandom);
    while (sb_out < 65535 && cyc < 90000) begin
      b_m_ready = ($urandom_range(0, 7) != 0);
      b_s_valid = (sb_in < 65535);
      #1;
      if (b_m_valid && b_m_ready) begin
        if (sb_q.size() == 0) sb_bad++;
        else begin
          exp_b = sb_q.pop_front();
          if (b_m_data !== exp_b || b_m_last !== 1'b1) sb_bad++;
        end
        sb_out++;
      end
      if (b_s_valid && b_s_ready) begin
        sb_q.push_back(b_s_data);
        sb_in++;
        @(negedge clk);
        b_s_data = 8'($urandom);
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    b_s_valid = 1'b0;
    chk("t5 beats out", sb_out, 32'd65535);
    chk("t5 scoreboard bad", sb_bad, 32'd0);
    chk("t5 words wrap", {16'd0, b_words_sent}, 32'd0);
    chk("t5 idle valid", {31'd0, b_m_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
